// File: rtl/ibex_register_file_fpga_scrub.sv
// Ibex FPGA register file with N async read ports, one write port and a
// hardware scrub engine that rewrites every word with WordResetVal.
module ibex_register_file_fpga_scrub #(
  parameter bit                    RV32E        = 1'b0,
  parameter int unsigned           DataWidth    = 32,
  parameter int unsigned           NumReadPorts = 2,
  parameter bit                    WriteBypass  = 1'b0,
  parameter bit                    WrenCheck    = 1'b0,
  parameter logic [DataWidth-1:0]  WordResetVal = '0,
  parameter logic [DataWidth-1:0]  WordZeroVal  = '0
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NumReadPorts*5-1:0]        raddr_i,
  output logic [NumReadPorts*DataWidth-1:0] rdata_o,
  input  logic [4:0]                       waddr_a_i,
  input  logic [DataWidth-1:0]             wdata_a_i,
  input  logic                             we_a_i,
  input  logic                             scrub_req_i,
  output logic                             scrub_busy_o,
  output logic                             scrub_done_o,
  output logic                             err_o
);

  localparam int unsigned          AddrWidth = RV32E ? 4 : 5;
  localparam int unsigned          NumWords  = 2 ** AddrWidth;
  localparam logic [AddrWidth-1:0] LastPtr   = AddrWidth'(NumWords - 1);

  typedef enum logic {
    IDLE,
    SCRUB
  } state_e;

  state_e                 state;
  logic [AddrWidth-1:0]   ptr;
  logic [NumWords-1:0]    valid;
  logic [DataWidth-1:0]   mem [NumWords];

  logic [AddrWidth-1:0]   waddr;
  logic [AddrWidth-1:0]   mem_addr;
  logic [DataWidth-1:0]   mem_wdata;
  logic                   core_we;
  logic                   scrub_step;
  logic                   scrub_we;
  logic                   mem_we;

  // Bit 4 of every address is dropped in RV32E.
  logic                   unused_addr_bits;
  assign unused_addr_bits = ^{raddr_i, waddr_a_i};

  assign waddr      = waddr_a_i[AddrWidth-1:0];
  assign core_we    = we_a_i && (waddr != '0);
  assign scrub_step = (state == SCRUB) && !core_we;
  assign scrub_we   = scrub_step && !valid[ptr];

  // Single RAM write port: a core write takes priority and stalls the scrub.
  assign mem_we    = core_we || scrub_we;
  assign mem_addr  = core_we ? waddr : ptr;
  assign mem_wdata = core_we ? wdata_a_i : WordResetVal;

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state        <= SCRUB;
      ptr          <= AddrWidth'(1);
      valid        <= '0;
      scrub_busy_o <= 1'b1;
      scrub_done_o <= 1'b0;
    end else begin
      scrub_done_o <= 1'b0;
      if (core_we) begin
        valid[waddr] <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (scrub_req_i) begin
            // Later assignment wins: a same-cycle core write stays invalid.
            state        <= SCRUB;
            ptr          <= AddrWidth'(1);
            valid        <= '0;
            scrub_busy_o <= 1'b1;
          end
        end
        SCRUB: begin
          if (scrub_step) begin
            ptr <= ptr + AddrWidth'(1);
            if (ptr == LastPtr) begin
              state        <= IDLE;
              scrub_busy_o <= 1'b0;
              scrub_done_o <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar p = 0; p < NumReadPorts; p++) begin : g_rd
    logic [AddrWidth-1:0] ra;
    logic [DataWidth-1:0] rd;

    assign ra = raddr_i[5*p +: AddrWidth];

    always_comb begin
      rd = mem[ra];
      if (ra == '0) begin
        rd = WordZeroVal;
      end else if (WriteBypass && core_we && (waddr == ra)) begin
        rd = wdata_a_i;
      end else if (!valid[ra]) begin
        rd = WordResetVal;
      end
    end

    assign rdata_o[DataWidth*p +: DataWidth] = rd;
  end

  if (WrenCheck) begin : g_wren_check
    assign err_o = mem_we && !(core_we || scrub_we);
  end else begin : g_no_wren_check
    assign err_o = 1'b0;
  end

endmodule

// File: tb/tb_ibex_register_file_fpga_scrub.sv
// Randomised bench: a 32-word bypass-free instance and a 16-word RV32E bypass
// instance share stimulus and are checked against word/valid/countdown models.
module tb_ibex_register_file_fpga_scrub;

  localparam logic [31:0] RST0  = 32'h5C5C_0001;
  localparam logic [31:0] ZERO0 = 32'h0000_0000;
  localparam logic [31:0] RST1  = 32'h0000_0000;
  localparam logic [31:0] ZERO1 = 32'h0000_0A0A;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [14:0] raddr = '0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic        we = 1'b0;
  logic        req = 1'b0;
  logic [95:0] rdata0, rdata1;
  logic        busy0, done0, err0, busy1, done1, err1;

  always #5 clk = ~clk;

  ibex_register_file_fpga_scrub #(
    .RV32E(1'b0), .DataWidth(32), .NumReadPorts(3), .WriteBypass(1'b0),
    .WrenCheck(1'b1), .WordResetVal(RST0), .WordZeroVal(ZERO0)
  ) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .raddr_i(raddr), .rdata_o(rdata0),
    .waddr_a_i(waddr), .wdata_a_i(wdata), .we_a_i(we), .scrub_req_i(req),
    .scrub_busy_o(busy0), .scrub_done_o(done0), .err_o(err0)
  );

  ibex_register_file_fpga_scrub #(
    .RV32E(1'b1), .DataWidth(32), .NumReadPorts(3), .WriteBypass(1'b1),
    .WrenCheck(1'b0), .WordResetVal(RST1), .WordZeroVal(ZERO1)
  ) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .raddr_i(raddr), .rdata_o(rdata1),
    .waddr_a_i(waddr), .wdata_a_i(wdata), .we_a_i(we), .scrub_req_i(req),
    .scrub_busy_o(busy1), .scrub_done_o(done1), .err_o(err1)
  );

  // Reference model: last written value, "written since last scrub start",
  // and remaining scrub steps for each instance.
  logic [31:0] v0 [32];
  bit          w0 [32];
  logic [31:0] v1 [16];
  bit          w1 [16];
  bit          b0, d0, b1, d1;
  int          r0, r1;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [31:0] exp0(input logic [4:0] a);
    if (a == 5'd0) return ZERO0;
    if (w0[a]) return v0[a];
    return RST0;
  endfunction

  function automatic logic [31:0] exp1(input logic [4:0] a);
    logic [3:0] m;
    m = a[3:0];
    if (m == 4'd0) return ZERO1;
    if (we && waddr[3:0] == m) return wdata;
    if (w1[m]) return v1[m];
    return RST1;
  endfunction

  task automatic do_reset(input int cycles);
    rst_n = 1'b0; we = 1'b0; req = 1'b0; waddr = '0; wdata = '0;
    repeat (cycles) @(negedge clk);
    rst_n = 1'b1;
    b0 = 1'b1; d0 = 1'b0; r0 = 31;
    b1 = 1'b1; d1 = 1'b0; r1 = 15;
    for (int i = 0; i < 32; i++) w0[i] = 1'b0;
    for (int i = 0; i < 16; i++) w1[i] = 1'b0;
  endtask

  // Drives one cycle from just after a negedge, checks every read port and
  // status output against the model, then advances the model over the edge.
  task automatic drive_cycle(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                             input logic rq, input logic [14:0] ra);
    bit c0, c1;
    we = w; waddr = wa; wdata = wd; req = rq; raddr = ra;
    #1;
    for (int p = 0; p < 3; p++) begin
      logic [4:0]  a;
      logic [31:0] e;
      a = ra[5*p +: 5];
      e = exp0(a);
      n_tests++;
      if (rdata0[32*p +: 32] !== e) begin
        n_fail++;
        $display("FAIL rd0 port%0d addr %0d: got %h want %h", p, a, rdata0[32*p +: 32], e);
      end
      e = exp1(a);
      n_tests++;
      if (rdata1[32*p +: 32] !== e) begin
        n_fail++;
        $display("FAIL rd1 port%0d addr %0d: got %h want %h", p, a, rdata1[32*p +: 32], e);
      end
    end
    n_tests++;
    if ({busy0, done0, err0} !== {b0, d0, 1'b0}) begin
      n_fail++;
      $display("FAIL status0 busy/done/err: got %b want %b", {busy0, done0, err0}, {b0, d0, 1'b0});
    end
    n_tests++;
    if ({busy1, done1, err1} !== {b1, d1, 1'b0}) begin
      n_fail++;
      $display("FAIL status1 busy/done/err: got %b want %b", {busy1, done1, err1}, {b1, d1, 1'b0});
    end
    @(posedge clk);
    c0 = w && (wa != 5'd0);
    c1 = w && (wa[3:0] != 4'd0);
    if (c0) begin v0[wa] = wd; w0[wa] = 1'b1; end
    if (c1) begin v1[wa[3:0]] = wd; w1[wa[3:0]] = 1'b1; end
    d0 = 1'b0;
    if (b0) begin
      if (!c0) begin
        r0--;
        if (r0 == 0) begin b0 = 1'b0; d0 = 1'b1; end
      end
    end else if (rq) begin
      b0 = 1'b1; r0 = 31;
      for (int i = 0; i < 32; i++) w0[i] = 1'b0;
    end
    d1 = 1'b0;
    if (b1) begin
      if (!c1) begin
        r1--;
        if (r1 == 0) begin b1 = 1'b0; d1 = 1'b1; end
      end
    end else if (rq) begin
      b1 = 1'b1; r1 = 15;
      for (int i = 0; i < 16; i++) w1[i] = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic idle_cycle();
    drive_cycle(1'b0, 5'd0, 32'd0, 1'b0, 15'($urandom));
  endtask

  task automatic wait_done0(input int start, input int want, input string name);
    int k;
    k = start;
    while (!done0 && k < 60) begin
      idle_cycle();
      k++;
    end
    n_tests++;
    if (k != want) begin
      n_fail++;
      $display("FAIL %s: done after %0d cycles, want %0d", name, k, want);
    end
  endtask

  task automatic test_reset();
    do_reset(3);
    n_tests++;
    if ({busy0, done0, err0, busy1, done1} !== 5'b10010) begin
      n_fail++;
      $display("FAIL reset_state: got %b want 10010", {busy0, done0, err0, busy1, done1});
    end
    wait_done0(0, 31, "scrub_len");
    idle_cycle();
    for (int a = 0; a < 32; a++) drive_cycle(1'b0, 5'd0, 32'd0, 1'b0, {3{5'(a)}});
  endtask

  task automatic test_stall();
    do_reset(2);
    idle_cycle();
    idle_cycle();
    drive_cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, {3{5'd5}});
    wait_done0(3, 32, "stall_len");
    drive_cycle(1'b0, 5'd0, 32'd0, 1'b0, {3{5'd5}});
    n_tests++;
    if (rdata0[31:0] !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL stall_x5: got %h want deadbeef", rdata0[31:0]);
    end
  endtask

  task automatic test_write_read();
    drive_cycle(1'b1, 5'd7, 32'h0000_1234, 1'b0, {3{5'd7}});
    drive_cycle(1'b0, 5'd0, 32'd0, 1'b0, {3{5'd7}});
    for (int i = 0; i < 40; i++)
      drive_cycle(1'($urandom), 5'($urandom), $urandom, 1'b0, 15'($urandom));
  endtask

  task automatic test_rescrub();
    drive_cycle(1'b1, 5'd3, 32'h0000_A5A5, 1'b0, {3{5'd3}});
    drive_cycle(1'b0, 5'd0, 32'd0, 1'b1, {3{5'd3}});
    n_tests++;
    if (rdata0[31:0] !== RST0) begin
      n_fail++;
      $display("FAIL rescrub_x3: got %h want %h", rdata0[31:0], RST0);
    end
    drive_cycle(1'b0, 5'd0, 32'd0, 1'b1, {3{5'd3}});
    wait_done0(2, 32, "rescrub_len");
    drive_cycle(1'b0, 5'd0, 32'd0, 1'b0, {3{5'd3}});
  endtask

  task automatic test_zero();
    drive_cycle(1'b1, 5'd0, 32'h0000_FFFF, 1'b0, 15'd0);
    drive_cycle(1'b0, 5'd0, 32'd0, 1'b0, 15'd0);
    drive_cycle(1'b1, 5'h13, 32'h0000_CAFE, 1'b0, {5'd3, 5'h13, 5'd3});
    drive_cycle(1'b0, 5'd0, 32'd0, 1'b0, {5'h13, 5'd3, 5'h10});
    n_tests++;
    if (rdata1[63:32] !== 32'h0000_CAFE) begin
      n_fail++;
      $display("FAIL rv32e_alias: got %h want 0000cafe", rdata1[63:32]);
    end
  endtask

  task automatic test_err_force();
    force dut0.mem_we = 1'b1;
    #1;
    n_tests++;
    if (err0 !== 1'b1) begin
      n_fail++;
      $display("FAIL err_forced: got %b want 1", err0);
    end
    release dut0.mem_we;
    #1;
    n_tests++;
    if (err0 !== 1'b0) begin
      n_fail++;
      $display("FAIL err_released: got %b want 0", err0);
    end
  endtask

  task automatic test_reset_mid();
    do_reset(2);
    repeat (9) idle_cycle();
    do_reset(1);
    wait_done0(0, 31, "reset_mid_len");
  endtask

  task automatic test_random();
    do_reset(2);
    for (int i = 0; i < 500; i++)
      drive_cycle($urandom_range(0, 2) == 0, 5'($urandom), $urandom,
                  $urandom_range(0, 29) == 0, 15'($urandom));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stall();
    test_write_read();
    test_rescrub();
    test_zero();
    test_err_force();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
